// File: rtl/forwarding_unit.sv
// forwarding_unit: operand-forwarding selects, load-use stall and WB write-port control
// for the 5-stage pipeline, from a three-slot EXE/MEM/WB destination tracker.
module forwarding_unit #(
    parameter int REG_BITS = 3,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_ID,
    input  logic [REG_BITS-1:0] Ra_ID,
    input  logic [REG_BITS-1:0] Rb_ID,
    input  logic [REG_BITS-1:0] Rd_ID,
    input  logic                useA_ID,
    input  logic                useB_ID,
    input  logic                RegWrite_ID,
    input  logic                MemRead_ID,
    input  logic                flush,
    output logic [1:0]          ForwardA,
    output logic [1:0]          ForwardB,
    output logic                stall,
    output logic [REG_BITS-1:0] DestinationRegister,
    output logic                WB_signals,
    output logic [CNT_BITS-1:0] stall_count
);
    typedef struct packed {
        logic                v;
        logic [REG_BITS-1:0] rd;
        logic                rw;
        logic                ld;
    } slot_t;

    slot_t               exe_q, mem_q, wb_q, exe_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                stall_raw, go;

    function automatic logic writes(input slot_t s, input logic [REG_BITS-1:0] r);
        return s.v & s.rw & (s.rd == r) & (r != '0);
    endfunction

    // Youngest producer wins; a load still in EXE has no data yet, so it never forwards.
    function automatic logic [1:0] fwd(input logic en, input logic [REG_BITS-1:0] r,
                                       input slot_t e, input slot_t m, input slot_t w,
                                       input logic stl);
        return !en                      ? 2'b00 :
               (writes(e, r) & ~e.ld)   ? (stl ? 2'b00 : 2'b01) :
               writes(m, r)             ? 2'b10 :
               writes(w, r)             ? 2'b11 : 2'b00;
    endfunction

    always_comb begin
        stall_raw = valid_ID & ~flush & exe_q.v & exe_q.ld & exe_q.rw & (exe_q.rd != '0) &
                    ((useA_ID & (Ra_ID == exe_q.rd)) | (useB_ID & (Rb_ID == exe_q.rd)));
        go        = valid_ID & ~flush & ~stall_raw;
        exe_d     = {go, Rd_ID, go & RegWrite_ID, go & MemRead_ID};
        cnt_d     = (stall_raw & ~&cnt_q) ? cnt_q + CNT_BITS'(1) : cnt_q;
    end

    assign stall               = reset & stall_raw;
    assign ForwardA            = reset ? fwd(valid_ID & useA_ID & (Ra_ID != '0), Ra_ID,
                                             exe_q, mem_q, wb_q, stall_raw) : 2'b00;
    assign ForwardB            = reset ? fwd(valid_ID & useB_ID & (Rb_ID != '0), Rb_ID,
                                             exe_q, mem_q, wb_q, stall_raw) : 2'b00;
    assign DestinationRegister = reset ? wb_q.rd : '0;
    assign WB_signals          = reset & wb_q.v & wb_q.rw & (wb_q.rd != '0);
    assign stall_count         = cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            exe_q <= exe_d;
            mem_q <= exe_q;
            wb_q  <= mem_q;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_forwarding_unit.sv
// tb_forwarding_unit: directed and random checks of forwarding_unit against an
// instruction-history reference model (forward code = age of youngest producer).
module tb_forwarding_unit;
    logic        clk = 1'b0;
    logic        reset, valid_ID, useA_ID, useB_ID, RegWrite_ID, MemRead_ID, flush;
    logic [2:0]  Ra_ID, Rb_ID, Rd_ID, DestinationRegister;
    logic [1:0]  ForwardA, ForwardB;
    logic        stall, WB_signals;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    forwarding_unit dut (
        .clk(clk), .reset(reset), .valid_ID(valid_ID), .Ra_ID(Ra_ID), .Rb_ID(Rb_ID),
        .Rd_ID(Rd_ID), .useA_ID(useA_ID), .useB_ID(useB_ID), .RegWrite_ID(RegWrite_ID),
        .MemRead_ID(MemRead_ID), .flush(flush), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .stall(stall), .DestinationRegister(DestinationRegister), .WB_signals(WB_signals),
        .stall_count(stall_count)
    );

    typedef struct {bit v; int rd; bit rw; bit ld;} ins_t;
    typedef struct {bit rst; bit v; int ra; int rb; int rd; bit ua; bit ub; bit rw; bit ld; bit fl;} stim_t;

    ins_t hist[$];
    int   cnt_m;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic stim_t mk(bit v, int ra, int rb, int rd, bit ua, bit ub, bit rw, bit ld, bit fl);
        stim_t s;
        s = '{rst: 1'b1, v: v, ra: ra, rb: rb, rd: rd, ua: ua, ub: ub, rw: rw, ld: ld, fl: fl};
        return s;
    endfunction

    function automatic stim_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic stim_t rst_step(stim_t s);
        stim_t t;
        t = s;
        t.rst = 1'b0;
        return t;
    endfunction

    function automatic void clear_hist();
        ins_t b;
        b = '{v: 1'b0, rd: 0, rw: 1'b0, ld: 1'b0};
        hist = {b, b, b};
        cnt_m = 0;
    endfunction

    // Expected select = age (1..3) of the youngest in-flight producer of r.
    function automatic int exp_fwd(bit v, bit u, int r, bit stl);
        ins_t p;
        if (!(v && u && r != 0)) return 0;
        for (int age = 1; age <= 3; age++) begin
            p = hist[age-1];
            if (p.v && p.rw && p.rd == r) begin
                if (age == 1 && p.ld) continue;
                return (age == 1 && stl) ? 0 : age;
            end
        end
        return 0;
    endfunction

    task automatic step(input stim_t s, input string tag);
        ins_t e, w, n;
        bit   stl, go;
        reset = s.rst; valid_ID = s.v; Ra_ID = s.ra[2:0]; Rb_ID = s.rb[2:0]; Rd_ID = s.rd[2:0];
        useA_ID = s.ua; useB_ID = s.ub; RegWrite_ID = s.rw; MemRead_ID = s.ld; flush = s.fl;
        #1;
        e   = hist[0];
        w   = hist[2];
        stl = s.v && !s.fl && e.v && e.ld && e.rw && e.rd != 0 &&
              ((s.ua && s.ra == e.rd) || (s.ub && s.rb == e.rd));
        if (s.rst) begin
            chk({tag, ".fa"}, 32'(ForwardA), exp_fwd(s.v, s.ua, s.ra, stl));
            chk({tag, ".fb"}, 32'(ForwardB), exp_fwd(s.v, s.ub, s.rb, stl));
            chk({tag, ".stall"}, 32'(stall), 32'(stl));
            chk({tag, ".dr"}, 32'(DestinationRegister), w.rd);
            chk({tag, ".wb"}, 32'(WB_signals), 32'(w.v && w.rw && w.rd != 0));
            chk({tag, ".cnt"}, 32'(stall_count), cnt_m);
        end else begin
            chk({tag, ".rfa"}, 32'(ForwardA), 0);
            chk({tag, ".rfb"}, 32'(ForwardB), 0);
            chk({tag, ".rstall"}, 32'(stall), 0);
            chk({tag, ".rdr"}, 32'(DestinationRegister), 0);
            chk({tag, ".rwb"}, 32'(WB_signals), 0);
        end
        @(posedge clk);
        if (!s.rst) clear_hist();
        else begin
            go = s.v && !s.fl && !stl;
            n  = '{v: go, rd: s.rd, rw: go && s.rw, ld: go && s.ld};
            hist.push_front(n);
            void'(hist.pop_back());
            if (stl && cnt_m != 16'hffff) cnt_m++;
        end
        @(negedge clk);
    endtask

    initial begin
        stim_t s;
        clear_hist();
        step(rst_step(nop()), "rst0");
        step(rst_step(nop()), "rst1");
        step(nop(), "idle");
        // back-to-back ALU dependency
        step(mk(1, 0, 0, 3, 0, 0, 1, 0, 0), "alu_p");
        step(mk(1, 3, 0, 0, 1, 0, 0, 0, 0), "alu_c");
        // distance 2 and 3 on source B
        step(mk(1, 0, 0, 5, 0, 0, 1, 0, 0), "d2_p");
        step(nop(), "d2_n");
        step(mk(1, 0, 5, 0, 0, 1, 0, 0, 0), "d2_c");
        step(mk(1, 0, 0, 5, 0, 0, 1, 0, 0), "d3_p");
        step(nop(), "d3_n1");
        step(nop(), "d3_n2");
        step(mk(1, 0, 5, 0, 0, 1, 0, 0, 0), "d3_c");
        // load-use: one stall, then MEM forward
        step(mk(1, 0, 0, 2, 0, 0, 1, 1, 0), "lu_p");
        step(mk(1, 2, 0, 0, 1, 0, 0, 0, 0), "lu_c0");
        step(mk(1, 2, 0, 0, 1, 0, 0, 0, 0), "lu_c1");
        // EXE beats MEM; R0 never forwards
        step(mk(1, 0, 0, 4, 0, 0, 1, 0, 0), "pr_m");
        step(mk(1, 0, 0, 4, 0, 0, 1, 0, 0), "pr_e");
        step(mk(1, 4, 4, 0, 1, 1, 0, 0, 0), "pr_c");
        step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0), "r0_p");
        step(mk(1, 0, 0, 0, 1, 1, 0, 0, 0), "r0_c");
        step(nop(), "r0_n1");
        step(nop(), "r0_n2");
        // flush beats stall
        step(mk(1, 0, 0, 1, 0, 0, 1, 1, 0), "fl_p");
        step(mk(1, 1, 0, 0, 1, 0, 0, 0, 1), "fl_c");
        step(mk(1, 1, 0, 0, 1, 0, 0, 0, 0), "fl_n");
        // reset with producers in flight
        step(mk(1, 0, 0, 1, 0, 0, 1, 0, 0), "rs_p1");
        step(mk(1, 0, 0, 2, 0, 0, 1, 1, 0), "rs_p2");
        step(mk(1, 0, 0, 3, 0, 0, 1, 0, 0), "rs_p3");
        step(rst_step(mk(1, 2, 3, 0, 1, 1, 0, 0, 0)), "rs_r");
        step(mk(1, 1, 2, 0, 1, 1, 0, 0, 0), "rs_a1");
        step(mk(1, 3, 3, 0, 1, 1, 0, 0, 0), "rs_a2");
        for (int i = 0; i < 400; i++) begin
            s     = mk($urandom_range(7) != 0, $urandom_range(4), $urandom_range(4), $urandom_range(4),
                       $urandom_range(1), $urandom_range(1), $urandom_range(3) != 0, 0,
                       $urandom_range(9) == 0);
            s.ld  = s.rw && ($urandom_range(2) == 0);
            s.rst = $urandom_range(39) != 0;
            step(s, "rnd");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
